// File: rtl/prefetch_unit_pkg.sv
// prefetch_unit_pkg: jump encodings and instruction-format helpers shared by the prefetch slice
package prefetch_unit_pkg;
  typedef enum logic [1:0] {
    JMP_SEQ  = 2'd0,
    JMP_REL  = 2'd1,
    JMP_ABS  = 2'd2,
    JMP_RSVD = 2'd3
  } jump_mode_e;
  function automatic int long_bit(input int word_width);
    return word_width - 1;
  endfunction
endpackage

// File: rtl/prefetch_unit_if.sv
// prefetch_unit_if: instruction memory request/response bus
interface prefetch_unit_if #(parameter int PC_WIDTH = 20, parameter int WORD_WIDTH = 16);
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_req;
  logic [WORD_WIDTH-1:0] imem_rdata;
  modport master (output imem_addr, imem_req, input imem_rdata);
  modport slave  (input imem_addr, imem_req, output imem_rdata);
endinterface

// File: rtl/prefetch_unit_fifo.sv
// prefetch_fifo: circular queue of {address, word} entries with single push and pop of one or two
module prefetch_fifo #(
  parameter int AW    = 20,
  parameter int WW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [AW-1:0]                push_addr,
  input  logic [WW-1:0]                push_word,
  input  logic                         pop,
  input  logic                         pop_two,
  output logic [AW-1:0]                head_addr,
  output logic [WW-1:0]                head_word,
  output logic [WW-1:0]                next_word,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] addr_q [DEPTH];
  logic [WW-1:0] word_q [DEPTH];
  logic [PW-1:0] rd, wr;
  always_comb begin
    head_addr = addr_q[rd];
    head_word = word_q[rd];
    next_word = word_q[rd + PW'(1)];
  end
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      addr_q[wr] <= push_addr;
      word_q[wr] <= push_word;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset || clear) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + PW'(1);
      if (pop) rd <= rd + (pop_two ? PW'(2) : PW'(1));
      count <= count + CW'(push) - (pop ? (pop_two ? CW'(2) : CW'(1)) : CW'(0));
    end
  end
endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: instruction prefetcher with redirect handling and one/two-word instruction assembly
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH   = 20,
  parameter int                  WORD_WIDTH = 16,
  parameter int                  DEPTH      = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  prefetch_unit_if.master             imem,
  input  logic [1:0]                  jump_mode,
  input  logic [8:0]                  branch_offset,
  input  logic [PC_WIDTH-1:0]         branch_target,
  input  logic                        flush,
  input  logic                        stall,
  output logic [2*WORD_WIDTH-1:0]     instr_out,
  output logic                        instr_long,
  output logic                        instr_valid,
  output logic [PC_WIDTH-1:0]         instr_pc,
  output logic [$clog2(DEPTH+1)-1:0]  queue_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int LB = long_bit(WORD_WIDTH);
  logic [PC_WIDTH-1:0]   pc, commit_pc, inflight_addr, target, head_addr;
  logic [WORD_WIDTH-1:0] head_word, next_word;
  logic                  inflight, redirect, issue, pop, head_long, nonempty;
  always_comb begin
    redirect       = jump_mode == JMP_ABS || jump_mode == JMP_REL || flush;
    target         = jump_mode == JMP_ABS ? branch_target :
                     jump_mode == JMP_REL ? commit_pc + {{(PC_WIDTH-9){branch_offset[8]}}, branch_offset} :
                     commit_pc;
    nonempty       = queue_count != '0;
    head_long      = nonempty && head_word[LB];
    instr_valid    = nonempty && (!head_word[LB] || queue_count >= CW'(2));
    instr_long     = instr_valid && head_long;
    instr_out      = !instr_valid ? '0 :
                     head_long ? {head_word, next_word} : {{WORD_WIDTH{1'b0}}, head_word};
    instr_pc       = nonempty ? head_addr : commit_pc;
    pop            = instr_valid && !stall && !redirect;
    // in-flight word is counted so the queue can always absorb it next cycle
    issue          = !reset && !redirect &&
                     ({1'b0, queue_count} + (CW+1)'(inflight) < (CW+1)'(DEPTH));
    imem.imem_req  = issue;
    imem.imem_addr = pc;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc            <= RESET_PC;
      commit_pc     <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= RESET_PC;
    end else begin
      inflight      <= issue;
      inflight_addr <= pc;
      pc            <= redirect ? target : issue ? pc + PC_WIDTH'(1) : pc;
      commit_pc     <= redirect ? target :
                       pop ? instr_pc + (head_long ? PC_WIDTH'(2) : PC_WIDTH'(1)) : commit_pc;
    end
  end
  prefetch_fifo #(.AW(PC_WIDTH), .WW(WORD_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect),
    .push      (inflight),
    .push_addr (inflight_addr),
    .push_word (imem.imem_rdata),
    .pop       (pop),
    .pop_two   (head_long),
    .head_addr (head_addr),
    .head_word (head_word),
    .next_word (next_word),
    .count     (queue_count)
  );
endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter PC_WIDTH, 20, instruction word address width.
REQ-002 Parameter WORD_WIDTH, 16, instruction memory word width.
REQ-003 Parameter DEPTH, 4, prefetch queue entries; power of two, >=2.
REQ-004 Parameter RESET_PC, 0, fetch address after reset.
REQ-005 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 imem_addr  output  PC_WIDTH  word address presented to instruction memory.
REQ-008 imem_req  output  1  high when imem_addr is a real fetch request this cycle.
REQ-009 imem_rdata  input  WORD_WIDTH  word for the address requested in the previous cycle.
REQ-010 jump_mode  input  2  0 sequential, 1 relative, 2 absolute, 3 treated as 0.
REQ-011 branch_offset  input  9  signed two's-complement word offset for relative jumps.
REQ-012 branch_target  input  PC_WIDTH  absolute jump address.
REQ-013 flush  input  1  discard all fetched words and replay from commit address.
REQ-014 stall  input  1  consumer not accepting the output instruction.
REQ-015 instr_out  output  2*WORD_WIDTH  assembled instruction; short form in low half, high half zero.
REQ-016 instr_long  output  1  instr_out holds a two-word instruction (first word in high half).
REQ-017 instr_valid  output  1  instr_out/instr_pc/instr_long are valid.
REQ-018 instr_pc  output  PC_WIDTH  address of the first word of instr_out.
REQ-019 queue_count  output  clog2(DEPTH+1)  words currently held in the queue.

Function
REQ-020 A request SHALL issue (imem_req=1, imem_addr=pc, pc<=pc+1) when queue_count plus in-flight requests < DEPTH and no redirect occurs that cycle.
REQ-021 Each issued word SHALL be written into the queue with its address exactly one cycle after issue.
REQ-022 A word whose bit WORD_WIDTH-1 is set SHALL be the first half of a long instruction; otherwise the word is short.
REQ-023 instr_valid SHALL be 1 when the head is short, or the head is long and a second word is queued; otherwise 0.
REQ-024 Pop occurs when instr_valid=1 and stall=0: 1 word (short) or 2 words (long) leave the queue; commit_pc <= instr_pc+1 or +2.
REQ-025 Redirect priority: jump_mode=2 > jump_mode=1 > flush.
REQ-026 jump_mode=2: pc <= branch_target; jump_mode=1: pc <= commit_pc + sign-extended branch_offset; flush alone: pc <= commit_pc.
REQ-027 On any redirect the queue SHALL empty and the in-flight word SHALL be discarded; no pop and no issue occur that cycle; commit_pc <= new pc.
REQ-028 instr_valid SHALL be 0 in the cycle after a redirect; the first post-redirect request issues that cycle, data usable two cycles after redirect.
REQ-029 Queue full: imem_req=0, pc and imem_addr hold.
REQ-030 Simultaneous push and pop in one cycle SHALL both take effect; queue_count changes by push minus pop.
REQ-031 PC and commit_pc arithmetic SHALL wrap modulo 2^PC_WIDTH; read/write pointers wrap modulo DEPTH.

Reset
REQ-032 While reset=1: pc=commit_pc=RESET_PC, queue empty, no in-flight, imem_req=0, instr_valid=0, instr_out=0, instr_long=0, instr_pc=RESET_PC, queue_count=0.
REQ-033 Reset asserted mid-operation SHALL abandon all queued and in-flight words immediately; first request issues at RESET_PC on the first edge after release.

Structure
REQ-034 A shared package SHALL hold the jump_mode encodings and the long-instruction flag bit position.
REQ-035 Queue storage and pointers SHALL be a sub-module prefetch_fifo (entries of {address, word}, push, pop of 1 or 2).

Verification
REQ-036 Reset release, stall=0, memory returns 0x0001 per address -> imem_addr 0,1,2..., first instr_valid with instr_pc=0 two cycles after release.
REQ-037 stall=1 for 10 cycles -> queue_count saturates at 4, imem_req=0, imem_addr holds 4; release -> pops resume in order.
REQ-038 Words 0x8001,0x1234 at addresses 5,6 -> one output, instr_long=1, instr_out=0x80011234, instr_pc=5, commit_pc becomes 7.
REQ-039 jump_mode=1, branch_offset=-4 while instr_pc=0x00010 -> queue cleared, next imem_addr 0x0000C, stale word not output.
REQ-040 jump_mode=2 and flush same cycle, branch_target=0xFFFFF -> fetch 0xFFFFF then 0x00000 (wrap); flush alone after commit_pc=8 -> refetch from 8.
